sensor_input_conditioner: RTL and testbench

Upstream front end for the irrigation controller. It conditions the six raw field sensor lines before the water-sensor checker, irrigation controller/selector and alarm logic use them. Each line is synchronised, then debounced. The block also produces a registered water-level conflict flag, a startup-valid flag and a change strobe. All outputs feed the existing combinational control path unchanged.

---
 rtl/sensor_input_conditioner.sv | 126 ++++++++++++
 tb/tb_sensor_input_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_input_conditioner.sv
// Field sensor front end: two-flop sync, per-line debounce,
// startup validity, water-probe conflict flag and change strobe.
module sensor_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_low_water_level,
  input  logic raw_mid_water_level,
  input  logic raw_high_water_level,
  input  logic raw_earth_humidity,
  input  logic raw_air_humidity,
  input  logic raw_low_temperature,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic conflicting_values,
  output logic sensors_valid,
  output logic sensors_changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int N = 6;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SU_LAST =
    CNT_W'(DEBOUNCE_CYCLES + 1);

  logic [N-1:0]     raw;
  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [N-1:0]     stable;
  logic [N-1:0]     gated;
  logic [N-1:0]     gated_q;
  logic [CNT_W-1:0] cnt [N];
  logic [CNT_W-1:0] su_cnt;
  logic             valid;
  logic             conflict;
  logic             changed;

  // bit 5 = low probe ... bit 0 = low temperature
  assign raw = {
    raw_low_water_level,
    raw_mid_water_level,
    raw_high_water_level,
    raw_earth_humidity,
    raw_air_humidity,
    raw_low_temperature
  };

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Counter stops one short of the settle edge so it always
  // fits in CNT_W; the valid flop supplies the final step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      su_cnt <= '0;
      valid  <= 1'b0;
    end else begin
      if (su_cnt != SU_LAST) begin
        su_cnt <= su_cnt + 1'b1;
      end
      if (su_cnt == SU_LAST) begin
        valid <= 1'b1;
      end
    end
  end

  assign gated = stable & {N{valid}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gated_q  <= '0;
      changed  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      gated_q  <= gated;
      changed  <= (gated != gated_q);
      conflict <= valid &
        ((gated[4] & ~gated[5]) |
         (gated[3] & ~gated[4]));
    end
  end

  assign low_water_level    = gated[5];
  assign mid_water_level    = gated[4];
  assign high_water_level   = gated[3];
  assign earth_humidity     = gated[2];
  assign air_humidity       = gated[1];
  assign low_temperature    = gated[0];
  assign conflicting_values = conflict;
  assign sensors_valid      = valid;
  assign sensors_changed    = changed;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: table rows plus timed
// corner sequences, checked through a cycle-stamped scoreboard.
module tb_sensor_input_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] raw;
  logic [5:0] raw2;
  wire  [8:0] v1;
  wire  [8:0] v2;

  always #5 clock = ~clock;

  sensor_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .raw_low_water_level(raw[5]),
    .raw_mid_water_level(raw[4]),
    .raw_high_water_level(raw[3]),
    .raw_earth_humidity(raw[2]),
    .raw_air_humidity(raw[1]),
    .raw_low_temperature(raw[0]),
    .low_water_level(v1[8]),
    .mid_water_level(v1[7]),
    .high_water_level(v1[6]),
    .earth_humidity(v1[5]),
    .air_humidity(v1[4]),
    .low_temperature(v1[3]),
    .conflicting_values(v1[2]),
    .sensors_valid(v1[1]),
    .sensors_changed(v1[0])
  );

  sensor_input_conditioner #(.DEBOUNCE_CYCLES(2)) dut2 (
    .clock(clock),
    .reset(reset),
    .raw_low_water_level(raw2[5]),
    .raw_mid_water_level(raw2[4]),
    .raw_high_water_level(raw2[3]),
    .raw_earth_humidity(raw2[2]),
    .raw_air_humidity(raw2[1]),
    .raw_low_temperature(raw2[0]),
    .low_water_level(v2[8]),
    .mid_water_level(v2[7]),
    .high_water_level(v2[6]),
    .earth_humidity(v2[5]),
    .air_humidity(v2[4]),
    .low_temperature(v2[3]),
    .conflicting_values(v2[2]),
    .sensors_valid(v2[1]),
    .sensors_changed(v2[0])
  );

  localparam logic [8:0] M_ALL  = 9'h1FF;
  localparam logic [8:0] M_OUT  = 9'h1F8;
  localparam logic [8:0] M_CONF = 9'h004;
  localparam logic [8:0] M_VAL  = 9'h002;
  localparam logic [8:0] M_CHG  = 9'h001;
  localparam logic [8:0] M_ERTH = 9'h020;
  localparam logic [8:0] M_HIGH = 9'h040;

  typedef struct {
    int         at;
    bit         sel;
    logic [8:0] mask;
    logic [8:0] val;
    string      tag;
  } exp_t;

  typedef struct {
    logic [5:0] raw;
    logic       conf;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[11];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [5:0] cur6;
  logic       cur_conf;

  task automatic chk(string tag, logic [8:0] act,
                     logic [8:0] mask, logic [8:0] val);
    checks++;
    if ((act & mask) !== (val & mask)) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b mask=%b",
               tag, cyc, act, val, mask);
    end
  endtask

  task automatic push(int at, bit sel, logic [8:0] mask,
                      logic [8:0] val, string tag);
    exp_t e;
    e.at   = at;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        chk(sb[i].tag, sb[i].sel ? v2 : v1,
            sb[i].mask, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic apply_row(logic [5:0] r6, logic cf);
    int c;
    c = cyc;
    raw = r6;
    push(c + 5, 0, M_OUT, {cur6, 3'b000}, "row_hold");
    push(c + 6, 0, M_OUT | M_CONF | M_CHG,
         {r6, cur_conf, 2'b00}, "row_flip");
    push(c + 7, 0, M_CONF | M_CHG | M_VAL,
         {6'b0, cf, 1'b1, (r6 != cur6)}, "row_conf");
    push(c + 8, 0, M_CONF | M_CHG,
         {6'b0, cf, 2'b00}, "row_quiet");
    repeat (9) @(negedge clock);
    cur6     = r6;
    cur_conf = cf;
  endtask

  initial begin
    int c;
    int r;
    tbl[0]  = '{6'b000000, 1'b0};
    tbl[1]  = '{6'b100000, 1'b0};
    tbl[2]  = '{6'b110000, 1'b0};
    tbl[3]  = '{6'b111000, 1'b0};
    tbl[4]  = '{6'b101000, 1'b1};
    tbl[5]  = '{6'b010000, 1'b1};
    tbl[6]  = '{6'b110000, 1'b0};
    tbl[7]  = '{6'b000111, 1'b0};
    tbl[8]  = '{6'b001010, 1'b1};
    tbl[9]  = '{6'b111111, 1'b0};
    tbl[10] = '{6'b000000, 1'b0};

    reset = 1'b1;
    raw   = '1;
    raw2  = '0;
    #2;
    chk("reset_dut", v1, M_ALL, 9'h000);
    chk("reset_dut2", v2, M_ALL, 9'h000);

    // startup with all lines high
    repeat (3) @(negedge clock);
    reset = 1'b0;
    r = cyc;
    for (int k = 1; k <= 5; k++) begin
      push(r + k, 0, M_ALL, 9'h000, "startup_low");
    end
    push(r + 6, 0, M_ALL, {6'h3F, 3'b010}, "startup_rise");
    push(r + 7, 0, M_ALL, {6'h3F, 3'b011}, "startup_pulse");
    push(r + 8, 0, M_ALL, {6'h3F, 3'b010}, "startup_quiet");
    repeat (10) @(negedge clock);
    cur6     = 6'h3F;
    cur_conf = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply_row(tbl[i].raw, tbl[i].conf);
    end

    // 3-cycle glitch, gap, then a 4-cycle pulse on earth
    c = cyc;
    for (int k = 1; k <= 17; k++) begin
      push(c + k, 0, M_ERTH | M_CHG,
           {3'b000, (k >= 11 && k <= 14), 4'b0000,
            (k == 12 || k == 16)}, "glitch");
    end
    raw[2] = 1'b1;
    repeat (3) @(negedge clock);
    raw[2] = 1'b0;
    repeat (2) @(negedge clock);
    raw[2] = 1'b1;
    repeat (4) @(negedge clock);
    raw[2] = 1'b0;
    while (cyc < c + 19) @(negedge clock);

    // reset while the high-probe count is partway
    apply_row(6'b100111, 1'b0);
    c = cyc;
    raw = 6'b101111;
    for (int k = 1; k <= 5; k++) begin
      push(c + k, 0, M_OUT | M_HIGH,
           {6'b100111, 3'b000}, "pre_reset");
    end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("async_reset", v1, M_ALL, 9'h000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    r = cyc;
    for (int k = 1; k <= 5; k++) begin
      push(r + k, 0, M_ALL, 9'h000, "revalidate_low");
    end
    push(r + 3, 1, M_ALL, 9'h000, "d2_startup_low");
    push(r + 4, 1, M_ALL, 9'h002, "d2_startup_valid");
    push(r + 6, 0, M_ALL, {6'b101111, 3'b010}, "reval_rise");
    push(r + 7, 0, M_ALL, {6'b101111, 3'b111}, "reval_pulse");
    push(r + 8, 0, M_ALL, {6'b101111, 3'b110}, "reval_quiet");
    repeat (10) @(negedge clock);
    cur6     = 6'b101111;
    cur_conf = 1'b1;

    // all six lines together on the short debounce
    c = cyc;
    raw2 = '1;
    push(c + 3, 1, M_ALL, 9'h002, "d2_up_hold");
    push(c + 4, 1, M_ALL, {6'h3F, 3'b010}, "d2_up_flip");
    push(c + 5, 1, M_ALL, {6'h3F, 3'b011}, "d2_up_pulse");
    push(c + 6, 1, M_ALL, {6'h3F, 3'b010}, "d2_up_quiet");
    repeat (6) @(negedge clock);
    c = cyc;
    raw2 = '0;
    push(c + 3, 1, M_ALL, {6'h3F, 3'b010}, "d2_dn_hold");
    push(c + 4, 1, M_ALL, 9'h002, "d2_dn_flip");
    push(c + 5, 1, M_ALL, 9'h003, "d2_dn_pulse");
    push(c + 6, 1, M_ALL, 9'h002, "d2_dn_quiet");
    repeat (8) @(negedge clock);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d need=0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
